// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multicycle CPU: FSM state codes, opcodes,
// and the select encodings used by the control unit and datapath.
package cpu_defs_pkg;

    // FSM state codes; the numeric values are visible on the debug port
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10
    } state_t;

    // Instruction opcodes, instruction[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU control encodings
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Control FSM for the multicycle single-memory datapath. Outputs are
// decoded from the registered state; only the FETCH-stage IR and PC loads
// also follow mem_ready so they fire on the cycle the fetch completes.
module multicycle_control
    import cpu_defs_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;

    // State register; reset aborts any instruction and parks the FSM in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // Next-state selection; memory states hold until the access completes
    always_comb begin
        state_d = S_IDLE;
        unique case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_RTYPE) begin
                    state_d = S_EXECUTE;
                end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                    state_d = S_MEMADR;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                // Only lw/sw reach here; anything else simply refetches
                if (opcode == OP_LW) begin
                    state_d = S_MEMREAD;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_IDLE;
        endcase
    end

    // Output decode; every control defaults to 0 and each state raises its own
    always_comb begin
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        illegal_op    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = SRCB_IMM_SHL;
                illegal_op = (opcode != OP_RTYPE) && (opcode != OP_LW) &&
                             (opcode != OP_SW) && (opcode != OP_BEQ) &&
                             (opcode != OP_J);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_source     = PCSRC_ALUOUT;
                pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_write  = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control: walks each instruction class
// cycle by cycle and compares the state code and full control word against
// hand-written expected values.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       illegal_op;
    logic [3:0] state;

    int total_count;
    int bad_count;

    // Control word: iord mem_read mem_write ir_write _ reg_dst mem_to_reg
    // reg_write alu_src_a _ alu_src_b _ alu_op _ pc_source _ pcw pcwc illegal
    logic [16:0] ctrl;
    assign ctrl = {iord, mem_read, mem_write, ir_write,
                   reg_dst, mem_to_reg, reg_write, alu_src_a,
                   alu_src_b, alu_op, pc_source,
                   pc_write, pc_write_cond, illegal_op};

    localparam logic [16:0] C_IDLE       = 17'b0000_0000_00_00_00_000;
    localparam logic [16:0] C_FETCH_RDY  = 17'b0101_0000_01_00_00_100;
    localparam logic [16:0] C_FETCH_WAIT = 17'b0100_0000_01_00_00_000;
    localparam logic [16:0] C_DECODE     = 17'b0000_0000_11_00_00_000;
    localparam logic [16:0] C_DECODE_ILL = 17'b0000_0000_11_00_00_001;
    localparam logic [16:0] C_MEMADR     = 17'b0000_0001_10_00_00_000;
    localparam logic [16:0] C_MEMREAD    = 17'b1100_0000_00_00_00_000;
    localparam logic [16:0] C_MEMWB      = 17'b0000_0110_00_00_00_000;
    localparam logic [16:0] C_MEMWRITE   = 17'b1010_0000_00_00_00_000;
    localparam logic [16:0] C_EXECUTE    = 17'b0000_0001_00_10_00_000;
    localparam logic [16:0] C_ALUWB      = 17'b0000_1010_00_00_00_000;
    localparam logic [16:0] C_BRANCH     = 17'b0000_0001_00_01_01_010;
    localparam logic [16:0] C_JUMP       = 17'b0000_0000_00_00_10_100;

    localparam logic [5:0] O_R   = 6'b000000;
    localparam logic [5:0] O_LW  = 6'b100011;
    localparam logic [5:0] O_SW  = 6'b101011;
    localparam logic [5:0] O_BEQ = 6'b000100;
    localparam logic [5:0] O_J   = 6'b000010;
    localparam logic [5:0] O_BAD = 6'b111111;

    multicycle_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends even if the sequence stalls
    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        bad_count = bad_count + 1;
        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_count = total_count + 1;
        if (got !== want) begin
            bad_count = bad_count + 1;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, check, then move to the next falling edge
    task automatic applyStimulus(input string tag, input logic [5:0] op, input logic rdy,
                                 input logic [3:0] exp_state, input logic [16:0] exp_ctrl);
        opcode    = op;
        mem_ready = rdy;
        #1;
        checkOutput({tag, ".state"}, {28'd0, state}, {28'd0, exp_state});
        checkOutput({tag, ".ctrl"}, {15'd0, ctrl}, {15'd0, exp_ctrl});
        @(negedge clk);
    endtask

    initial begin
        total_count = 0;
        bad_count   = 0;
        rst_n       = 1'b0;
        opcode      = O_R;
        mem_ready   = 1'b1;

        // Reset held for three cycles
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("reset", O_R, 1'b1, 4'd0, C_IDLE);
        end
        rst_n = 1'b1;
        applyStimulus("rel_idle", O_R, 1'b1, 4'd0, C_IDLE);

        // R-type, opcode changed during EXECUTE must not matter
        applyStimulus("r_fetch",  O_R,   1'b1, 4'd1, C_FETCH_RDY);
        applyStimulus("r_decode", O_R,   1'b1, 4'd2, C_DECODE);
        applyStimulus("r_exec",   O_BAD, 1'b1, 4'd7, C_EXECUTE);
        applyStimulus("r_aluwb",  O_BAD, 1'b1, 4'd8, C_ALUWB);

        // lw with a fetch stall and two memory-read stall cycles
        applyStimulus("lw_fwait", O_LW, 1'b0, 4'd1, C_FETCH_WAIT);
        applyStimulus("lw_fetch", O_LW, 1'b1, 4'd1, C_FETCH_RDY);
        applyStimulus("lw_dec",   O_LW, 1'b1, 4'd2, C_DECODE);
        applyStimulus("lw_adr",   O_LW, 1'b1, 4'd3, C_MEMADR);
        applyStimulus("lw_rd0",   O_LW, 1'b0, 4'd4, C_MEMREAD);
        applyStimulus("lw_rd1",   O_J,  1'b0, 4'd4, C_MEMREAD);
        applyStimulus("lw_rd2",   O_J,  1'b1, 4'd4, C_MEMREAD);
        applyStimulus("lw_wb",    O_J,  1'b1, 4'd5, C_MEMWB);

        // sw then beq
        applyStimulus("sw_fetch", O_SW,  1'b1, 4'd1, C_FETCH_RDY);
        applyStimulus("sw_dec",   O_SW,  1'b1, 4'd2, C_DECODE);
        applyStimulus("sw_adr",   O_SW,  1'b1, 4'd3, C_MEMADR);
        applyStimulus("sw_wr",    O_SW,  1'b1, 4'd6, C_MEMWRITE);
        applyStimulus("beq_fetch",O_BEQ, 1'b1, 4'd1, C_FETCH_RDY);
        applyStimulus("beq_dec",  O_BEQ, 1'b1, 4'd2, C_DECODE);
        applyStimulus("beq_br",   O_BEQ, 1'b1, 4'd9, C_BRANCH);

        // jump
        applyStimulus("j_fetch",  O_J, 1'b1, 4'd1,  C_FETCH_RDY);
        applyStimulus("j_dec",    O_J, 1'b1, 4'd2,  C_DECODE);
        applyStimulus("j_jump",   O_J, 1'b1, 4'd10, C_JUMP);

        // illegal opcode: single-cycle flag in DECODE, straight back to FETCH
        applyStimulus("ill_fetch", O_BAD, 1'b1, 4'd1, C_FETCH_RDY);
        applyStimulus("ill_dec",   O_BAD, 1'b1, 4'd2, C_DECODE_ILL);
        applyStimulus("ill_back",  O_BAD, 1'b0, 4'd1, C_FETCH_WAIT);
        applyStimulus("ill_fetch2",O_SW,  1'b1, 4'd1, C_FETCH_RDY);

        // sw stalled in MEMWRITE, then reset asserted mid-access
        applyStimulus("rs_dec",   O_SW, 1'b1, 4'd2, C_DECODE);
        applyStimulus("rs_adr",   O_SW, 1'b1, 4'd3, C_MEMADR);
        applyStimulus("rs_wr",    O_SW, 1'b0, 4'd6, C_MEMWRITE);
        rst_n = 1'b0;
        #1;
        checkOutput("rs_async.state", {28'd0, state}, 32'd0);
        checkOutput("rs_async.mem_write", {31'd0, mem_write}, 32'd0);
        @(negedge clk);
        applyStimulus("rs_hold",  O_SW, 1'b0, 4'd0, C_IDLE);
        rst_n = 1'b1;
        applyStimulus("rs_idle",  O_SW, 1'b0, 4'd0, C_IDLE);
        applyStimulus("rs_fetch", O_SW, 1'b0, 4'd1, C_FETCH_WAIT);

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control FSM for the multicycle single-memory datapath. Decodes the 6-bit opcode and sequences FETCH/DECODE/execute/write-back. Drives the select lines of the datapath's 2:1 muxes (`S` inputs) plus all write enables. Stalls on memory states until the memory reports ready.

## Interface
Parameters: none. Opcodes are fixed constants (see Structure).

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  instruction[31:26] from the instruction register
- `mem_ready`  in  1  memory completes the current access this cycle
- `iord`  out  1  address mux select: 0 = PC, 1 = ALUOut
- `mem_read`  out  1  memory read request
- `mem_write`  out  1  memory write request
- `ir_write`  out  1  load instruction register
- `reg_dst`  out  1  write-register select: 0 = rt, 1 = rd
- `mem_to_reg`  out  1  write-data select: 0 = ALUOut, 1 = MDR
- `reg_write`  out  1  register-file write enable
- `alu_src_a`  out  1  0 = PC, 1 = A
- `alu_src_b`  out  2  00 = B, 01 = 4, 10 = sign-ext imm, 11 = imm<<2
- `alu_op`  out  2  00 = add, 01 = sub, 10 = funct-decoded
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `pc_write`  out  1  unconditional PC load
- `pc_write_cond`  out  1  PC load if ALU zero
- `illegal_op`  out  1  one-cycle pulse on an unrecognised opcode
- `state`  out  4  current state code (debug)

## Operation
- States and codes: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECUTE=7, ALUWB=8, BRANCH=9, JUMP=10. Codes 11–15 are illegal and go to IDLE on the next edge.
- IDLE: all outputs 0. Goes to FETCH unconditionally.
- FETCH: mem_read=1, alu_src_b=01. ir_write and pc_write equal mem_ready (Mealy). Goes to DECODE when mem_ready=1; otherwise holds.
- DECODE: alu_src_b=11. Next state is chosen by opcode:
  - R-type 000000 → EXECUTE
  - lw 100011 or sw 101011 → MEMADR
  - beq 000100 → BRANCH
  - j 000010 → JUMP
  - any other opcode → FETCH, with illegal_op=1 in DECODE.
- MEMADR: alu_src_a=1, alu_src_b=10. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: iord=1, mem_read=1. Goes to MEMWB on mem_ready; holds otherwise.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEMWRITE: iord=1, mem_write=1. Goes to FETCH on mem_ready; holds otherwise.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_source=01, pc_write_cond=1. Goes to FETCH.
- JUMP: pc_source=10, pc_write=1. Goes to FETCH.
- Any output not listed for a state is 0 in that state.

## Timing
- Reset: rst_n low forces state=IDLE immediately (asynchronous), so every output is 0. The first edge after release enters FETCH.
- Reset mid-instruction aborts the instruction. No write enable may be asserted while rst_n is low.
- Outputs decode combinationally from registered state. Only ir_write and pc_write in FETCH also depend on mem_ready.
- Instruction latency with mem_ready tied 1, counted as cycles FETCH→FETCH:
  - R-type 4, lw 5, sw 4, beq 3, j 3, illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Memory request outputs stay stable during the stall.
- opcode is sampled only in DECODE and MEMADR. It may change in any other state without effect.

## Structure
- Shared package `cpu_defs_pkg` holds:
  - state enum/codes
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J)
  - alu_op encodings (ALU_ADD, ALU_SUB, ALU_FUNCT)
  - alu_src_b and pc_source select encodings
- Single module: one state register, one next-state block, one output decode block. No sub-module.
- The 2:1 muxes consuming iord, reg_dst, mem_to_reg and alu_src_a are existing datapath instances.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release → state=0 and all outputs 0 during reset; state=1 one edge after release.
- R-type 000000, mem_ready=1 → states 1,2,7,8,1. In state 8: reg_write=1, reg_dst=1, mem_to_reg=0.
- lw 100011 with mem_ready low for 2 cycles in MEMREAD → states 1,2,3,4,4,4,5,1. iord=1 and mem_read=1 throughout state 4. ir_write pulses only in FETCH.
- sw 101011 then beq 000100 → sw runs 1,2,3,6,1 with mem_write=1 in state 6. beq runs 1,2,9,1 with pc_write_cond=1, alu_op=01, pc_source=01 in state 9.
- Opcode 111111 → illegal_op=1 for exactly the DECODE cycle, then FETCH. reg_write, mem_write and pc_write are never asserted.
- rst_n pulsed low during MEMWRITE with mem_ready=0 → mem_write drops to 0 immediately; the FSM restarts at IDLE then FETCH.
